// File: rtl/rf_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// x0 always reads as zero and is never busy; optional same-cycle write-to-read bypass.
module rf_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter bit          BYPASS = 1'b0,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                any_busy
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;

  // Later write ports overwrite earlier ones, and issue overrides the
  // busy-clear of a same-cycle write so the newest producer wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
      busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
          mem[wr_addr[j*AW +: AW]]  <= wr_data[j*XLEN +: XLEN];
          busy[wr_addr[j*AW +: AW]] <= 1'b0;
        end
      end
      if (iss_en && (iss_addr != '0)) begin
        busy[iss_addr] <= 1'b1;
      end
    end
  end

  assign any_busy = |busy[DEPTH-1:1];

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rbsy;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      rdat = mem[ra];
      rbsy = busy[ra];
      if (BYPASS) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
            rdat = wr_data[j*XLEN +: XLEN];
            rbsy = 1'b0;
          end
        end
      end
      if (ra == '0) begin
        rdat = '0;
        rbsy = 1'b0;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = rdat;
    assign rd_busy[i]              = rbsy;
  end

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: a non-bypass and a bypass instance (both dual-write) share
// stimulus; a reference model pushes expected outputs to a scoreboard queue.
module tb_rf_mp;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  logic [NRD*XLEN-1:0] rd_data0, rd_data1;
  logic [NRD-1:0]      rd_busy0, rd_busy1;
  logic                any_busy0, any_busy1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string              tag;
    logic [NRD*XLEN-1:0] d0;
    logic [NRD-1:0]      b0;
    logic                a0;
    logic [NRD*XLEN-1:0] d1;
    logic [NRD-1:0]      b1;
    logic                a1;
  } exp_t;

  exp_t exp_q[$];

  logic [XLEN-1:0] m_data [DEPTH];
  logic [DEPTH-1:0] m_busy;

  rf_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .any_busy(any_busy0)
  );

  rf_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .any_busy(any_busy1)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < DEPTH; k++) m_data[k] = '0;
    m_busy = '0;
  end

  // Reference state update on the same edge the DUTs update.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) m_data[k] = '0;
      m_busy = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
          m_data[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
          m_busy[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (iss_en && iss_addr != '0) m_busy[iss_addr] = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t predict(input string tag);
    exp_t e;
    logic [AW-1:0] ra;
    logic [XLEN-1:0] d;
    logic b;
    e.tag = tag;
    for (int bp = 0; bp < 2; bp++) begin
      for (int i = 0; i < NRD; i++) begin
        ra = rd_addr[i*AW +: AW];
        d  = m_data[ra];
        b  = m_busy[ra];
        if (bp == 1) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
              d = wr_data[j*XLEN +: XLEN];
              b = 1'b0;
            end
          end
        end
        if (ra == '0) begin
          d = '0;
          b = 1'b0;
        end
        if (bp == 0) begin
          e.d0[i*XLEN +: XLEN] = d;
          e.b0[i] = b;
        end else begin
          e.d1[i*XLEN +: XLEN] = d;
          e.b1[i] = b;
        end
      end
    end
    e.a0 = |m_busy;
    e.a1 = |m_busy;
    return e;
  endfunction

  // Drive one cycle of stimulus, predict, then compare away from the edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic [1:0] wen,
                               input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
                               input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
                               input logic iss, input logic [AW-1:0] ia,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    wr_en    = wen;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    iss_en   = iss;
    iss_addr = ia;
    rd_addr  = {ra1, ra0};
    exp_q.push_back(predict(tag));
    #2;
    e = exp_q.pop_front();
    checkOutput({e.tag, ".nb.data"}, 64'(rd_data0), 64'(e.d0));
    checkOutput({e.tag, ".nb.busy"}, 64'(rd_busy0), 64'(e.b0));
    checkOutput({e.tag, ".nb.any"},  64'(any_busy0), 64'(e.a0));
    checkOutput({e.tag, ".bp.data"}, 64'(rd_data1), 64'(e.d1));
    checkOutput({e.tag, ".bp.busy"}, 64'(rd_busy1), 64'(e.b1));
    checkOutput({e.tag, ".bp.any"},  64'(any_busy1), 64'(e.a1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
    repeat (2) @(posedge clk);

    // reset clears stored data
    applyStimulus("rst_wr",   1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0);
    applyStimulus("rst_pre",  0, 2'b00, 0, 0, 0, 0, 1, 5, 5, 0);
    applyStimulus("rst_post", 1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);

    // write visibility and x0
    applyStimulus("wr7_same", 1, 2'b01, 7, 32'h12345678, 0, 0, 0, 0, 7, 0);
    applyStimulus("wr7_next", 1, 2'b10, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 7, 0);
    applyStimulus("x0_read",  1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7);

    // bypass, first non-busy then busy
    applyStimulus("byp_nb",   1, 2'b01, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 3, 0);
    applyStimulus("iss3",     1, 2'b00, 0, 0, 0, 0, 1, 3, 3, 0);
    applyStimulus("byp_busy", 1, 2'b10, 0, 0, 3, 32'h5A5A5A5A, 0, 0, 3, 3);
    applyStimulus("byp_after",1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0);

    // dual-write conflict
    applyStimulus("dual_same",1, 2'b11, 9, 32'h1, 9, 32'h2, 0, 0, 9, 0);
    applyStimulus("dual_next",1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0);

    // scoreboard sequence
    applyStimulus("iss10",    1, 2'b00, 0, 0, 0, 0, 1, 10, 10, 0);
    applyStimulus("wr10",     1, 2'b01, 10, 32'h55, 0, 0, 0, 0, 10, 0);
    applyStimulus("iss_wr10", 1, 2'b01, 10, 32'h66, 0, 0, 1, 10, 10, 0);
    applyStimulus("chk10",    1, 2'b10, 0, 0, 10, 32'h77, 0, 0, 10, 0);
    applyStimulus("iss0",     1, 2'b00, 0, 0, 0, 0, 1, 0, 10, 0);
    applyStimulus("any_idle", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 10);

    // reset while work is pending
    applyStimulus("iss4",     1, 2'b00, 0, 0, 0, 0, 1, 4, 4, 12);
    applyStimulus("iss12",    1, 2'b00, 0, 0, 0, 0, 1, 12, 4, 12);
    applyStimulus("rst_pend", 0, 2'b00, 0, 0, 0, 0, 1, 6, 4, 12);
    applyStimulus("post_pend",1, 2'b00, 0, 0, 0, 0, 0, 0, 6, 4);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      applyStimulus("rand", ($urandom_range(0, 19) != 0), 2'($urandom),
                    AW'($urandom), $urandom, AW'($urandom), $urandom,
                    1'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rf_mp.md
Name: rf_mp

Overview:
- Parametrised multi-port integer register file for the rv32 core, with a per-register pending-write scoreboard.
- Supports configurable data width, depth, read-port count and write-port count, plus optional same-cycle write-to-read bypass.
- Sits between decode/issue (read operands, mark destinations busy) and writeback (commit results, clear busy).
- Register 0 is hardwired to zero and is never busy.

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of architectural registers including x0. Power of two, at least 2.
- NRD, 2, number of read ports. Range 1..4.
- NWR, 1, number of write ports. Range 1..2.
- BYPASS, 0. When 1, read ports forward same-cycle write data and busy-clear. When 0, writes are visible only from the next cycle.
- AW, $clog2(DEPTH), address width. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rd_addr  in  NRD*AW  read addresses; port i is at bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i is at bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  per read port, 1 = addressed register has a pending write.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  issue strobe; marks iss_addr busy.
- iss_addr  in  AW  destination register being issued.
- any_busy  out  1  OR of all busy bits (drain/fence indication).

Behaviour:
- **State.** Registers data[1..DEPTH-1] are XLEN wide; busy[1..DEPTH-1] are 1 bit. x0 has no storage.
- **Reset.** Reset is synchronous, active-low. On a rising edge of clk with rst_n=0:
  - all data and all busy bits are cleared to 0;
  - wr_en and iss_en are ignored in that cycle.
  - Outputs are combinational, so after that edge rd_data=0, rd_busy=0 and any_busy=0 for every address.
  - Reset asserted mid-operation discards pending busy bits with no residual state.
- **Reads.** Reads are combinational, 0-cycle latency.
  - rd_addr=0 gives rd_data=0 and rd_busy=0 regardless of any other input.
  - With BYPASS=0: rd_data = data[rd_addr] and rd_busy = busy[rd_addr].
  - With BYPASS=1: if some wr_en[j] is set with wr_addr[j]==rd_addr!=0, rd_data = wr_data of the winning write port and rd_busy=0. Otherwise the BYPASS=0 behaviour applies.
  - The issue input never bypasses into rd_busy. A register issued this cycle reads busy only from the next cycle.
- **Writes.** Writes take effect on the clock edge.
  - wr_en[j] && wr_addr[j]!=0 causes data[wr_addr[j]] <= wr_data[j].
  - Writes to x0 are dropped.
  - Two ports writing the same address in the same cycle: the higher port index wins, for both storage and bypass.
- **Scoreboard.**
  - iss_en && iss_addr!=0 sets busy[iss_addr] at the next edge.
  - Any enabled write to address a clears busy[a] at the next edge.
  - Issue and write to the same address in the same cycle: busy ends set (the new producer wins), and data still takes the write.
  - Issue to an already-busy register leaves it busy. There is no counting.
  - A write to a non-busy register updates data; busy stays 0.
- **any_busy.** any_busy = OR of busy[1..DEPTH-1], registered state only.
- **Out-of-range.** Out-of-range addresses are impossible because DEPTH = 2**AW.

Test Plan:
- **Reset clears state.** Apply reset; write 0xDEADBEEF to x5; pulse rst_n=0 for one edge. Required: rd_data for x5 = 0, rd_busy = 0, any_busy = 0.
- **Write and x0 handling (BYPASS=0).** wr x7 = 0x12345678; read x7 in the same cycle → old value 0. Read x7 next cycle → 0x12345678. wr x0 = 0xFFFFFFFF → reading x0 returns 0.
- **Bypass (BYPASS=1).** wr x3 = 0xA5A5A5A5 while rd_addr0 = 3. Required: rd_data0 = 0xA5A5A5A5 in the same cycle. Repeat with x3 busy → rd_busy0 = 0 in that cycle.
- **Dual-write conflict (NWR=2).** Port0 x9 = 0x1, port1 x9 = 0x2 in the same cycle. Required: x9 = 0x2 next cycle; with BYPASS=1, rd_data = 0x2 in the same cycle.
- **Scoreboard sequence.**
  - iss x10 → next cycle rd_busy = 1, any_busy = 1.
  - wr x10 = 0x55 → next cycle rd_busy = 0, any_busy = 0, data = 0x55.
  - iss x10 together with wr x10 = 0x66 → busy = 1, data = 0x66.
  - iss x0 → any_busy stays 0.
- **Reset during pending work.** Busy set on x4 and x12; assert rst_n low for one edge while iss_en=1 on x6. Required: all busy = 0, any_busy = 0, and x6 not busy afterwards.
